// File: rtl/imem_loadable_fetch.sv
// Byte-addressed instruction memory with a registered fetch port and a
// valid/ready program loader; sits between the PC register and IF/ID.
module imem_loadable_fetch #(
  parameter int          DEPTH_BYTES = 1024,
  parameter logic [31:0] BUBBLE_INST = 32'h0000_0000,
  parameter int          STALL_MODE  = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] out_inst,
  output logic        out_valid,
  output logic        misalign_err,
  output logic        oob_err,
  input  logic        load_start,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_done,
  output logic [1:0]  dbg_state_o
);

  // Loader handshake: a beat transfers on a rising edge where load_valid and
  // load_ready are both high; load_ready is high exactly while in LOADING.

  localparam int          WORDS         = DEPTH_BYTES / 4;
  localparam int          PW            = $clog2(WORDS);
  localparam int          AW            = PW + 2;
  localparam logic [31:0] LAST_ADDR     = 32'(DEPTH_BYTES - 4);
  localparam logic [PW-1:0] PTR_MAX     = PW'(WORDS - 1);
  localparam bit          HOLD_ON_STALL = (STALL_MODE != 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOADING = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  state_e          state_q;
  logic [PW-1:0]   ptr_q;
  logic            load_ready_q;
  logic            load_done_q;

  logic [7:0]      mem_q [DEPTH_BYTES];

  logic [31:0]     out_inst_q, out_inst_d;
  logic            out_valid_q, out_valid_d;
  logic            misalign_q, misalign_d;
  logic            oob_q, oob_d;

  logic            beat_fire;
  logic [PW-1:0]   rd_word_idx;
  logic [31:0]     rd_word;

  assign beat_fire = (state_q == S_LOADING) && load_valid;

  // Contents survive reset; only the loader ever writes the array.
  always_ff @(posedge clock) begin
    if (!reset && beat_fire) begin
      mem_q[{ptr_q, 2'd0}] <= load_data[31:24];
      mem_q[{ptr_q, 2'd1}] <= load_data[23:16];
      mem_q[{ptr_q, 2'd2}] <= load_data[15:8];
      mem_q[{ptr_q, 2'd3}] <= load_data[7:0];
    end
  end

  assign rd_word_idx = pc[AW-1:2];
  assign rd_word = {mem_q[{rd_word_idx, 2'd0}], mem_q[{rd_word_idx, 2'd1}],
                    mem_q[{rd_word_idx, 2'd2}], mem_q[{rd_word_idx, 2'd3}]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      load_ready_q <= 1'b0;
      load_done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          load_done_q <= 1'b0;
          if (load_start) begin
            state_q      <= S_LOADING;
            ptr_q        <= '0;
            load_ready_q <= 1'b1;
          end
        end
        S_LOADING: begin
          if (load_valid) begin
            if (load_last || ptr_q == PTR_MAX) begin
              state_q      <= S_DONE;
              load_ready_q <= 1'b0;
              load_done_q  <= 1'b1;
            end
            // A full memory stops the pointer rather than wrapping it.
            if (ptr_q != PTR_MAX) begin
              ptr_q <= ptr_q + PW'(1);
            end
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          load_done_q <= 1'b0;
        end
        default: begin
          state_q      <= S_IDLE;
          load_ready_q <= 1'b0;
          load_done_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    out_inst_d  = BUBBLE_INST;
    out_valid_d = 1'b0;
    misalign_d  = 1'b0;
    oob_d       = 1'b0;
    if (state_q == S_IDLE && !flush) begin
      if (stall) begin
        if (HOLD_ON_STALL) begin
          out_inst_d  = out_inst_q;
          out_valid_d = out_valid_q;
          misalign_d  = misalign_q;
          oob_d       = oob_q;
        end
      end else if (pc[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end else if (pc > LAST_ADDR) begin
        oob_d = 1'b1;
      end else begin
        out_inst_d  = rd_word;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_inst_q  <= BUBBLE_INST;
      out_valid_q <= 1'b0;
      misalign_q  <= 1'b0;
      oob_q       <= 1'b0;
    end else begin
      out_inst_q  <= out_inst_d;
      out_valid_q <= out_valid_d;
      misalign_q  <= misalign_d;
      oob_q       <= oob_d;
    end
  end

  assign out_inst     = out_inst_q;
  assign out_valid    = out_valid_q;
  assign misalign_err = misalign_q;
  assign oob_err      = oob_q;
  assign load_ready   = load_ready_q;
  assign load_done    = load_done_q;
  assign dbg_state_o  = state_q;

endmodule
